// File: rtl/udp_csr_pkg.sv
// Shared definitions for the UDP/Ethernet AXI-Lite CSR bank: register map,
// response codes, FSM state types and configuration reset defaults.
package udp_csr_pkg;

    localparam int unsigned OFS_CTRL   = 32'h00;
    localparam int unsigned OFS_STATUS = 32'h04;
    localparam int unsigned OFS_MAC_LO = 32'h08;
    localparam int unsigned OFS_MAC_HI = 32'h0C;
    localparam int unsigned OFS_SRC_IP = 32'h10;
    localparam int unsigned OFS_DST_IP = 32'h14;
    localparam int unsigned OFS_PORTS  = 32'h18;
    localparam int unsigned OFS_TX_CNT = 32'h1C;
    localparam int unsigned OFS_RX_CNT = 32'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [47:0] DEF_SRC_MAC = 48'h000A35000001;
    localparam logic [31:0] DEF_SRC_IP  = 32'hC0A8010A;
    localparam logic [31:0] DEF_DST_IP  = 32'hC0A80164;
    localparam logic [31:0] DEF_PORTS   = 32'h04D204D2;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Merge new write data into an old register value, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/udp_pkt_counter.sv
// 32-bit packet counter: increments on a done pulse, wraps naturally,
// and a clear request wins over a coincident increment.
module udp_pkt_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_clr,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 32'd1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/axi_lite_udp_csr.sv
// AXI4-Lite slave register bank holding UDP/Ethernet configuration and
// exposing link status and TX/RX packet counters.
module axi_lite_udp_csr
    import udp_csr_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter logic [47:0] RST_SRC_MAC = DEF_SRC_MAC,
    parameter logic [31:0] RST_SRC_IP  = DEF_SRC_IP,
    parameter logic [31:0] RST_DST_IP  = DEF_DST_IP,
    parameter logic [31:0] RST_PORTS   = DEF_PORTS
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] S_AXI_awaddr,
    input  logic        S_AXI_awvalid,
    output logic        S_AXI_awready,
    input  logic [31:0] S_AXI_wdata,
    input  logic [3:0]  S_AXI_wstrb,
    input  logic        S_AXI_wvalid,
    output logic        S_AXI_wready,
    output logic [1:0]  S_AXI_bresp,
    output logic        S_AXI_bvalid,
    input  logic        S_AXI_bready,
    input  logic [31:0] S_AXI_araddr,
    input  logic        S_AXI_arvalid,
    output logic        S_AXI_arready,
    output logic [31:0] S_AXI_rdata,
    output logic [1:0]  S_AXI_rresp,
    output logic        S_AXI_rvalid,
    input  logic        S_AXI_rready,
    output logic        tx_en,
    output logic        rx_en,
    output logic        soft_rst,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    input  logic        link_up,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic        rx_done
);

    localparam int IW   = ADDR_W - 2;
    localparam int NREG = 2 ** IW;

    localparam logic [IW-1:0] A_CTRL   = IW'(OFS_CTRL   >> 2);
    localparam logic [IW-1:0] A_STATUS = IW'(OFS_STATUS >> 2);
    localparam logic [IW-1:0] A_MAC_LO = IW'(OFS_MAC_LO >> 2);
    localparam logic [IW-1:0] A_MAC_HI = IW'(OFS_MAC_HI >> 2);
    localparam logic [IW-1:0] A_SRC_IP = IW'(OFS_SRC_IP >> 2);
    localparam logic [IW-1:0] A_DST_IP = IW'(OFS_DST_IP >> 2);
    localparam logic [IW-1:0] A_PORTS  = IW'(OFS_PORTS  >> 2);
    localparam logic [IW-1:0] A_TX_CNT = IW'(OFS_TX_CNT >> 2);
    localparam logic [IW-1:0] A_RX_CNT = IW'(OFS_RX_CNT >> 2);

    wr_state_t r_wstate, w_wnext;
    rd_state_t r_rstate, w_rnext;
    logic      w_wacc, w_racc;

    logic [1:0]  r_ctrl;
    logic [31:0] r_mac_lo;
    logic [15:0] r_mac_hi;
    logic [31:0] r_src_ip, r_dst_ip, r_ports;
    logic        r_soft_rst;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic [IW-1:0] w_widx, w_ridx;
    logic [31:0]   w_regs [NREG];
    logic [31:0]   w_wmerge;
    logic [31:0]   w_tx_cnt, w_rx_cnt;
    logic          w_tx_clr, w_rx_clr;
    logic          w_unused_addr;

    assign w_widx = S_AXI_awaddr[ADDR_W-1:2];
    assign w_ridx = S_AXI_araddr[ADDR_W-1:2];
    assign w_unused_addr = ^{S_AXI_awaddr[31:ADDR_W], S_AXI_awaddr[1:0],
                             S_AXI_araddr[31:ADDR_W], S_AXI_araddr[1:0]};

    // Readable view of every decoded slot; unmapped slots read as zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) w_regs[i] = '0;
        w_regs[A_CTRL]   = {30'b0, r_ctrl};
        w_regs[A_STATUS] = {30'b0, tx_busy, link_up};
        w_regs[A_MAC_LO] = r_mac_lo;
        w_regs[A_MAC_HI] = {16'b0, r_mac_hi};
        w_regs[A_SRC_IP] = r_src_ip;
        w_regs[A_DST_IP] = r_dst_ip;
        w_regs[A_PORTS]  = r_ports;
        w_regs[A_TX_CNT] = w_tx_cnt;
        w_regs[A_RX_CNT] = w_rx_cnt;
    end

    assign w_wmerge = apply_strb(w_regs[w_widx], S_AXI_wdata, S_AXI_wstrb);

    // Write channel: address and data are only taken together.
    always_comb begin
        w_wnext = r_wstate;
        w_wacc  = 1'b0;
        case (r_wstate)
            W_IDLE: if (S_AXI_awvalid && S_AXI_wvalid && !ARESET) begin
                w_wacc  = 1'b1;
                w_wnext = W_RESP;
            end
            W_RESP: if (S_AXI_bready) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_wstate <= W_IDLE;
        else        r_wstate <= w_wnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        w_racc  = 1'b0;
        case (r_rstate)
            R_IDLE: if (S_AXI_arvalid && !ARESET) begin
                w_racc  = 1'b1;
                w_rnext = R_DATA;
            end
            R_DATA: if (S_AXI_rready) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rnext;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_ctrl     <= '0;
            r_mac_lo   <= RST_SRC_MAC[31:0];
            r_mac_hi   <= RST_SRC_MAC[47:32];
            r_src_ip   <= RST_SRC_IP;
            r_dst_ip   <= RST_DST_IP;
            r_ports    <= RST_PORTS;
            r_bresp    <= RESP_OKAY;
            r_soft_rst <= 1'b0;
        end else begin
            r_soft_rst <= w_wacc && (w_widx == A_CTRL) && w_wmerge[2];
            if (w_wacc) begin
                r_bresp <= (w_widx <= A_RX_CNT) ? RESP_OKAY : RESP_SLVERR;
                case (w_widx)
                    A_CTRL:   r_ctrl   <= w_wmerge[1:0];
                    A_MAC_LO: r_mac_lo <= w_wmerge;
                    A_MAC_HI: r_mac_hi <= w_wmerge[15:0];
                    A_SRC_IP: r_src_ip <= w_wmerge;
                    A_DST_IP: r_dst_ip <= w_wmerge;
                    A_PORTS:  r_ports  <= w_wmerge;
                    default: ;
                endcase
            end
        end
    end

    // Read data is captured at accept, so a same-cycle write is not yet visible.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_racc) begin
            r_rdata <= w_regs[w_ridx];
            r_rresp <= (w_ridx <= A_RX_CNT) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign w_tx_clr = w_wacc && (w_widx == A_TX_CNT);
    assign w_rx_clr = w_wacc && (w_widx == A_RX_CNT);

    udp_pkt_counter u_tx_cnt (
        .i_clk (ACLK),
        .i_rst (ARESET),
        .i_inc (tx_done),
        .i_clr (w_tx_clr),
        .o_cnt (w_tx_cnt)
    );

    udp_pkt_counter u_rx_cnt (
        .i_clk (ACLK),
        .i_rst (ARESET),
        .i_inc (rx_done),
        .i_clr (w_rx_clr),
        .o_cnt (w_rx_cnt)
    );

    assign S_AXI_awready = w_wacc;
    assign S_AXI_wready  = w_wacc;
    assign S_AXI_bvalid  = (r_wstate == W_RESP);
    assign S_AXI_bresp   = r_bresp;
    assign S_AXI_arready = w_racc;
    assign S_AXI_rvalid  = (r_rstate == R_DATA);
    assign S_AXI_rdata   = r_rdata;
    assign S_AXI_rresp   = r_rresp;

    assign tx_en    = r_ctrl[0];
    assign rx_en    = r_ctrl[1];
    assign soft_rst = r_soft_rst;
    assign src_mac  = {r_mac_hi, r_mac_lo};
    assign src_ip   = r_src_ip;
    assign dst_ip   = r_dst_ip;
    assign src_port = r_ports[31:16];
    assign dst_port = r_ports[15:0];

endmodule

// File: tb/tb_axi_lite_udp_csr.sv
// Scoreboard bench for axi_lite_udp_csr: stimulus queues expected B/R responses,
// a negedge monitor pops and compares them when the DUT presents a response.
module tb_axi_lite_udp_csr;
    import udp_csr_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        tx_en, rx_en, soft_rst;
    logic [47:0] src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic        link_up = 0, tx_busy = 0, tx_done = 0, rx_done = 0;

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;

    always #5 ACLK = ~ACLK;

    axi_lite_udp_csr dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_awaddr(awaddr), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
        .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
        .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
        .tx_en(tx_en), .rx_en(rx_en), .soft_rst(soft_rst), .src_mac(src_mac),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .link_up(link_up), .tx_busy(tx_busy), .tx_done(tx_done), .rx_done(rx_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Monitor: bready/rready only change just after posedge, so negedge sampling is race-free.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) tmo("unexpected_bresp");
                else begin
                    mon_b = bq.pop_front();
                    chk("bresp", bresp, mon_b);
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) tmo("unexpected_rdata");
                else begin
                    mon_r = rq.pop_front();
                    chk("rdata_rresp", {rdata, rresp}, mon_r);
                end
            end
        end
    end

    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] e);
        int n;
        n = 0;
        bq.push_back(e);
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        #1;
        while (!(awready && wready) && n < 20) begin @(negedge ACLK); #1; n++; end
        if (n >= 20) tmo("aw_accept");
        @(posedge ACLK); #1;
        chk("bvalid_latency", bvalid, 1);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic rd_issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] e);
        int n;
        n = 0;
        rq.push_back({d, e});
        @(negedge ACLK);
        araddr = a; arvalid = 1;
        #1;
        while (!arready && n < 20) begin @(negedge ACLK); #1; n++; end
        if (n >= 20) tmo("ar_accept");
        @(posedge ACLK); #1;
        chk("rvalid_latency", rvalid, 1);
        arvalid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin @(negedge ACLK); #1; n++; end
        if (n >= 50) tmo("response_drain");
        @(posedge ACLK); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] e);
        wr_issue(a, d, s, e);
        wait_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] e);
        rd_issue(a, d, e);
        wait_idle();
    endtask

    // One channel is presented alone for three cycles before the other joins.
    task automatic wr_staged(input logic aw_first, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bq.push_back(RESP_OKAY);
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s;
        if (aw_first) awvalid = 1; else wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("no_accept_alone", {awready, wready}, 2'b00);
            @(negedge ACLK);
        end
        awvalid = 1; wvalid = 1;
        #1;
        chk("accept_together", {awready, wready}, 2'b11);
        @(posedge ACLK); #1;
        chk("bvalid_next_cycle", bvalid, 1);
        awvalid = 0; wvalid = 0;
        wait_idle();
    endtask

    task automatic pulse(input logic tx, input logic rx);
        @(negedge ACLK);
        tx_done = tx; rx_done = rx;
        @(negedge ACLK);
        tx_done = 0; rx_done = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: valids presented during reset must not be accepted
        repeat (2) @(negedge ACLK);
        awvalid = 1; wvalid = 1; arvalid = 1;
        #1;
        chk("reset_ready", {awready, wready, arready}, 3'b000);
        @(negedge ACLK);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("reset_valid", {bvalid, rvalid}, 2'b00);
        chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
        chk("reset_ctrl_out", {tx_en, rx_en, soft_rst}, 3'b000);
        chk("reset_mac", src_mac, 48'h000A35000001);
        chk("reset_ips", {src_ip, dst_ip}, 64'hC0A8010A_C0A80164);
        chk("reset_ports", {src_port, dst_port}, {16'd1234, 16'd1234});
        ARESET = 0;

        rd(32'h10, 32'hC0A8010A, RESP_OKAY);

        // Byte-lane write after AW-first and W-first ordering
        wr_staged(1'b1, 32'h14, 32'h0000BEEF, 4'b0011);
        rd(32'h14, 32'hC0A8BEEF, RESP_OKAY);
        chk("dst_ip_out", dst_ip, 32'hC0A8BEEF);
        wr_staged(1'b0, 32'h08, 32'h11223344, 4'hF);
        wr(32'h0C, 32'hDEAD5678, 4'hF, RESP_OKAY);
        rd(32'h08, 32'h11223344, RESP_OKAY);
        rd(32'h0C, 32'h00005678, RESP_OKAY);
        chk("src_mac_out", src_mac, 48'h5678_11223344);

        // CTRL: soft_rst is a single-cycle pulse and reads back as 0
        wr_issue(32'h00, 32'h7, 4'hF, RESP_OKAY);
        chk("ctrl_pulse", {tx_en, rx_en, soft_rst}, 3'b111);
        @(posedge ACLK); #1;
        chk("soft_rst_one_cycle", soft_rst, 0);
        wait_idle();
        rd(32'h00, 32'h3, RESP_OKAY);

        // Backpressure: responses held stable, no new address accepted
        bready = 0; rready = 0;
        wr_issue(32'h18, 32'hAAAA5555, 4'hF, RESP_OKAY);
        rd_issue(32'h18, 32'hAAAA5555, RESP_OKAY);
        @(negedge ACLK);
        awaddr = 32'h00; wdata = 32'h0; awvalid = 1; wvalid = 1; araddr = 32'h00; arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold", {bvalid, rvalid, awready, arready, bresp, rresp}, 8'b1100_0000);
            chk("stall_rdata", rdata, 32'hAAAA5555);
            @(negedge ACLK);
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(posedge ACLK); #1;
        bready = 1; rready = 1;
        wait_idle();
        chk("ports_out", {src_port, dst_port}, 32'hAAAA5555);

        // Unmapped space and address aliasing
        rd(32'h24, 32'h0, RESP_SLVERR);
        wr(32'h30, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
        chk("unmapped_no_change", {src_ip, dst_ip}, 64'hC0A8010A_C0A8BEEF);
        chk("unmapped_no_change_ctrl", {tx_en, rx_en, soft_rst}, 3'b110);
        rd(32'h1000_0010, 32'hC0A8010A, RESP_OKAY);

        // STATUS is read-only
        link_up = 1; tx_busy = 1;
        rd(32'h04, 32'h3, RESP_OKAY);
        wr(32'h04, 32'h0, 4'hF, RESP_OKAY);
        link_up = 1; tx_busy = 0;
        rd(32'h04, 32'h1, RESP_OKAY);

        // Simultaneous read and write of SRC_IP: read sees the old value
        bq.push_back(RESP_OKAY);
        rq.push_back({32'hC0A8010A, RESP_OKAY});
        @(negedge ACLK);
        awaddr = 32'h10; wdata = 32'h0A0B0C0D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h10; arvalid = 1;
        #1;
        chk("dual_accept", {awready, arready}, 2'b11);
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        wait_idle();
        rd(32'h10, 32'h0A0B0C0D, RESP_OKAY);

        // Counters
        pulse(1, 1); pulse(1, 1); pulse(1, 0);
        rd(32'h1C, 32'd3, RESP_OKAY);
        rd(32'h20, 32'd2, RESP_OKAY);
        wr(32'h20, 32'h1234, 4'hF, RESP_OKAY);
        rd(32'h20, 32'd0, RESP_OKAY);
        @(negedge ACLK);
        force dut.u_tx_cnt.r_cnt = 32'hFFFFFFFF;
        #1;
        release dut.u_tx_cnt.r_cnt;
        rd(32'h1C, 32'hFFFFFFFF, RESP_OKAY);
        pulse(1, 0);
        rd(32'h1C, 32'd0, RESP_OKAY);
        pulse(1, 0);
        rd(32'h1C, 32'd1, RESP_OKAY);
        bq.push_back(RESP_OKAY);
        @(negedge ACLK);
        awaddr = 32'h1C; wdata = 32'h0; wstrb = 4'h0; awvalid = 1; wvalid = 1; tx_done = 1;
        #1;
        chk("clr_accept", awready, 1);
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; tx_done = 0;
        wait_idle();
        rd(32'h1C, 32'd0, RESP_OKAY);

        // Reset with both responses pending: dropped, config restored
        bready = 0; rready = 0;
        wr_issue(32'h14, 32'h12345678, 4'hF, RESP_OKAY);
        rd_issue(32'h00, 32'h3, RESP_OKAY);
        @(negedge ACLK);
        ARESET = 1;
        @(negedge ACLK);
        chk("midreset_valid", {bvalid, rvalid}, 2'b00);
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_cfg", {src_ip, dst_ip, tx_en, rx_en}, {64'hC0A8010A_C0A80164, 2'b00});
        bq.delete();
        rq.delete();
        ARESET = 0;
        @(posedge ACLK); #1;
        bready = 1; rready = 1;
        rd(32'h1C, 32'd0, RESP_OKAY);
        rd(32'h14, 32'hC0A80164, RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
